// File: rtl/mmu_pkg.sv
// Shared definitions for the l1mmu port arbiter: arbitration mode codes,
// default bus widths and the arbiter state encoding.
package mmu_pkg;

  // Arbitration modes selectable through the ARB_MODE parameter.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Default widths of the l1mmu line port.
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  // Two-state arbiter: IDLE picks a winner, BUSY holds it until mmu_done.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } arb_state_t;

  // Width of a port index; never less than one bit.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mmu_port_arbiter_if.sv
// Bundle of requester-side and l1mmu-side signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding requesters and l1mmu model.
interface mmu_port_arbiter_if
  import mmu_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_W    = DEF_LINE_W
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  // Handshake: a requester raises req_read and/or req_write (level) together
  // with a stable address and write line and holds all of them until it sees
  // its bit of req_done for one cycle; it may drop or re-issue the request in
  // the following cycle. Toward l1mmu, mmu_read/mmu_write stay high for the
  // whole transaction and l1mmu answers with a one-cycle mmu_done, with
  // mmu_rdata valid in that same cycle.
  logic [NUM_PORTS-1:0]        req_read;
  logic [NUM_PORTS-1:0]        req_write;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*LINE_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_done;
  logic [LINE_W-1:0]           req_rdata;

  logic                        mmu_read;
  logic                        mmu_write;
  logic [ADDR_W-1:0]           mmu_addr;
  logic [LINE_W-1:0]           mmu_wdata;
  logic                        mmu_done;
  logic [LINE_W-1:0]           mmu_rdata;

  logic                        grant_valid;
  logic [IDX_W-1:0]            grant_id;
  arb_state_t                  dbg_state;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mmu_done, mmu_rdata,
    output req_done, req_rdata, mmu_read, mmu_write, mmu_addr, mmu_wdata,
    output grant_valid, grant_id, dbg_state
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mmu_done, mmu_rdata,
    input  req_done, req_rdata, mmu_read, mmu_write, mmu_addr, mmu_wdata,
    input  grant_valid, grant_id, dbg_state
  );

endinterface

// File: rtl/arb_pick.sv
// Rotating-priority picker: searches the candidate set starting at 'start'
// and wrapping around. Starved ports, when any of them is pending, form the
// candidate set on their own so they beat every non-starved port.
module arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     start,
  input  logic [NUM_PORTS-1:0] starved,
  output logic [IDX_W-1:0]     winner,
  output logic                 found
);

  logic [NUM_PORTS-1:0] cand;

  // Restrict the search to starved ports whenever one of them is pending.
  always_comb begin
    cand = ((pending & starved) != '0) ? (pending & starved) : pending;
  end

  // First candidate at or after 'start', wrapping past the last index.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(start) + k) % NUM_PORTS;
      if (!found && cand[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// N-port arbiter in front of the single l1mmu line port. A winner is
// registered in IDLE and held for the whole transaction; address, write line
// and request type are forwarded live from the granted port while BUSY.
// Fixed priority (with optional starvation promotion) or round-robin.
module mmu_port_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int LINE_W       = DEF_LINE_W,
  parameter int ARB_MODE     = ARB_FIXED,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  mmu_port_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam bit USE_STARVE = (ARB_MODE == ARB_FIXED) && (STARVE_LIMIT > 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     wait_cnt_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] pending;
  logic [NUM_PORTS-1:0] starved;
  logic [IDX_W-1:0]     pick_start;
  logic [IDX_W-1:0]     pick_winner;
  logic                 pick_found;
  logic                 grant_now;
  logic                 busy;

  logic [ADDR_W-1:0]    sel_addr;
  logic [LINE_W-1:0]    sel_wdata;
  logic                 sel_read;
  logic                 sel_write;

  assign pending = bus.req_read | bus.req_write;
  assign busy    = (state_q == S_BUSY);

  // A port is promoted once its wait counter has saturated at the limit.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      starved[i] = USE_STARVE && (wait_cnt_q[i] == CNT_MAX);
    end
  end

  // Round-robin search begins just after the last granted port; fixed
  // priority always begins at port 0.
  always_comb begin
    pick_start = '0;
    if (ARB_MODE == ARB_RR) begin
      pick_start = (rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .pending (pending),
    .start   (pick_start),
    .starved (starved),
    .winner  (pick_winner),
    .found   (pick_found)
  );

  // Next-state logic: grant in IDLE, release on mmu_done in BUSY.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    grant_now  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_BUSY;
          grant_id_d = pick_winner;
          grant_now  = 1'b1;
          if (ARB_MODE == ARB_RR) begin
            rr_ptr_d = pick_winner;
          end
        end
      end
      S_BUSY: begin
        if (bus.mmu_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= LAST_IDX;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Wait counters: count grants lost while pending, saturating at the limit;
  // cleared on own grant, when idle-requesting stops, or in round-robin mode.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!rst_n || !USE_STARVE || !pending[i]) begin
        wait_cnt_q[i] <= '0;
      end else if (grant_now) begin
        if (pick_winner == IDX_W'(i)) begin
          wait_cnt_q[i] <= '0;
        end else if (wait_cnt_q[i] != CNT_MAX) begin
          wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Select the granted port's request, address and write line.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_read  = 1'b0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*LINE_W +: LINE_W];
        sel_read  = bus.req_read[i];
        sel_write = bus.req_write[i];
      end
    end
  end

  // Forward to l1mmu while BUSY (write wins over read) and route completion
  // back to the granted port only; mmu_done seen in IDLE is dropped.
  always_comb begin
    bus.mmu_read  = busy & sel_read & ~sel_write;
    bus.mmu_write = busy & sel_write;
    bus.mmu_addr  = busy ? sel_addr  : '0;
    bus.mmu_wdata = busy ? sel_wdata : '0;
    bus.req_done  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (busy && bus.mmu_done && (grant_id_q == IDX_W'(i))) begin
        bus.req_done[i] = 1'b1;
      end
    end
  end

  assign bus.req_rdata   = bus.mmu_rdata;
  assign bus.grant_valid = busy;
  assign bus.grant_id    = grant_id_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_mmu_port_arbiter.sv
// Bench for mmu_port_arbiter: three instances (2-port fixed without
// promotion, 2-port fixed with STARVE_LIMIT=3, 4-port round-robin) sharing
// clock and reset. A cycle table drives the first instance; grant-order
// sequences and a write-forwarding sequence cover the others.
module tb_mmu_port_arbiter;
  import mmu_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int NV = 25;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]    exp_q[$];
  logic [LW-1:0] rdata_a5;
  logic [LW-1:0] pat;

  typedef struct packed {
    logic        rst_n;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        done;
    logic        gv;
    logic        gid;
    logic        mr;
    logic        mw;
    logic [1:0]  rdone;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [NV];

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- DUTs ----------------
  mmu_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW)) a_if ();
  mmu_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW)) b_if ();
  mmu_port_arbiter_if #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW)) c_if ();

  mmu_port_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW),
                     .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(0)) u_a (
    .sys_clk (sys_clk), .rst_n (rst_n), .bus (a_if));

  mmu_port_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .LINE_W(LW),
                     .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(3)) u_b (
    .sys_clk (sys_clk), .rst_n (rst_n), .bus (b_if));

  mmu_port_arbiter #(.NUM_PORTS(4), .ADDR_W(AW), .LINE_W(LW),
                     .ARB_MODE(ARB_RR), .STARVE_LIMIT(8)) u_c (
    .sys_clk (sys_clk), .rst_n (rst_n), .bus (c_if));

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_done(input int which, input logic v);
    case (which)
      0:       a_if.mmu_done = v;
      1:       b_if.mmu_done = v;
      default: c_if.mmu_done = v;
    endcase
  endtask

  task automatic sample(input int which, output logic gv,
                        output logic [1:0] gid, output logic [3:0] rdn);
    case (which)
      0: begin
        gv = a_if.grant_valid; gid = 2'(a_if.grant_id); rdn = 4'(a_if.req_done);
      end
      1: begin
        gv = b_if.grant_valid; gid = 2'(b_if.grant_id); rdn = 4'(b_if.req_done);
      end
      default: begin
        gv = c_if.grant_valid; gid = c_if.grant_id; rdn = c_if.req_done;
      end
    endcase
  endtask

  // l1mmu responder: completes each grant on its second BUSY cycle and
  // compares the completing port against the head of exp_q.
  task automatic run_order(input int which, input string tag);
    logic       gv;
    logic [1:0] gid;
    logic [3:0] rdn;
    logic [1:0] exp_id;
    logic       busy_seen;
    busy_seen = 1'b0;
    for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
      @(negedge sys_clk);
      drive_done(which, 1'b0);
      sample(which, gv, gid, rdn);
      if (gv && busy_seen) begin
        drive_done(which, 1'b1);
        busy_seen = 1'b0;
        #1;
        sample(which, gv, gid, rdn);
        exp_id = exp_q.pop_front();
        check({tag, "_grant"}, LW'(gid), LW'(exp_id));
        check({tag, "_req_done"}, LW'(rdn), LW'(4'b0001 << exp_id));
      end else begin
        busy_seen = gv;
      end
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d grants outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    @(negedge sys_clk);
    drive_done(which, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Cycle table for instance A: rst, rd, wr, done | gv, gid, mr, mw, req_done, addr
    vecs = '{
      '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // reset held, port 1 pending
      '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // IDLE samples port 1
      '{1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 32'h200},  // port 1 forwarded
      '{1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h200},  // done -> 2'b10
      '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},
      '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // stray done in IDLE
      '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},
      '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h100},
      '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h100},  // reset while BUSY
      '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // abandoned, stray done
      '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},
      '{1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h100},
      '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // re-request: idle gap
      '{1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h100},
      '{1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h100},
      '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},
      '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // read+write on port 0
      '{1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h100},  // write wins
      '{1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h100},
      '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},
      '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},    // both pending
      '{1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h100},
      '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h100},
      '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0},
      '{1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 32'h100}   // port 0 again
    };

    rdata_a5 = {32{8'hA5}};
    for (int i = 0; i < LW / 32; i++) pat[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);

    a_if.req_read = '0; a_if.req_write = '0; a_if.mmu_done = 1'b0;
    a_if.req_addr = {32'h0000_0200, 32'h0000_0100};
    a_if.req_wdata = '0; a_if.mmu_rdata = rdata_a5;
    b_if.req_read = '0; b_if.req_write = '0; b_if.mmu_done = 1'b0;
    b_if.req_addr = '0; b_if.req_wdata = '0; b_if.mmu_rdata = '0;
    c_if.req_read = '0; c_if.req_write = '0; c_if.mmu_done = 1'b0;
    c_if.req_addr = '0; c_if.req_wdata = '0; c_if.mmu_rdata = '0;

    // ---- reset ----
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    #1;
    check("rst_a_gv",  LW'(a_if.grant_valid), LW'(0));
    check("rst_a_gid", LW'(a_if.grant_id), LW'(0));
    check("rst_b_state", LW'(b_if.dbg_state), LW'(S_IDLE));
    check("rst_c_gv",  LW'(c_if.grant_valid), LW'(0));
    check("rst_c_gid", LW'(c_if.grant_id), LW'(0));

    // ---- table-driven cycles on instance A ----
    for (int i = 0; i < NV; i++) begin
      @(negedge sys_clk);
      rst_n          = vecs[i].rst_n;
      a_if.req_read  = vecs[i].rd;
      a_if.req_write = vecs[i].wr;
      a_if.mmu_done  = vecs[i].done;
      #1;
      check($sformatf("row%0d_gv", i), LW'(a_if.grant_valid), LW'(vecs[i].gv));
      if (vecs[i].gv) check($sformatf("row%0d_gid", i), LW'(a_if.grant_id), LW'(vecs[i].gid));
      check($sformatf("row%0d_mmu_read", i), LW'(a_if.mmu_read), LW'(vecs[i].mr));
      check($sformatf("row%0d_mmu_write", i), LW'(a_if.mmu_write), LW'(vecs[i].mw));
      check($sformatf("row%0d_req_done", i), LW'(a_if.req_done), LW'(vecs[i].rdone));
      check($sformatf("row%0d_mmu_addr", i), LW'(a_if.mmu_addr), LW'(vecs[i].addr));
      check($sformatf("row%0d_req_rdata", i), a_if.req_rdata, rdata_a5);
    end

    // ---- A: no promotion, port 0 always wins ----
    repeat (6) exp_q.push_back(2'd0);
    run_order(0, "a_fixed");
    a_if.req_read = '0;

    // ---- B: STARVE_LIMIT=3, order 0,0,0,1,0,0,0,1 ----
    @(negedge sys_clk);
    b_if.req_read = 2'b11;
    foreach (vecs[i]) if (i < 8) exp_q.push_back((i % 4 == 3) ? 2'd1 : 2'd0);
    run_order(1, "b_starve");
    b_if.req_read = '0;

    // ---- C: round-robin, all pending then only ports 1 and 3 ----
    @(negedge sys_clk);
    c_if.req_read = 4'b1111;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    run_order(2, "c_rr_all");
    c_if.req_read = 4'b1010;
    exp_q = '{2'd1, 2'd3, 2'd1};
    run_order(2, "c_rr_13");
    c_if.req_read = '0;

    // ---- C: write forwarding from port 2 behind a port 0 read ----
    @(negedge sys_clk);
    c_if.req_read = 4'b0001;
    c_if.req_addr[0 +: AW] = 32'h0000_0300;
    #1;
    check("wf_idle_gv", LW'(c_if.grant_valid), LW'(0));
    @(negedge sys_clk);
    c_if.req_read  = 4'b0101;
    c_if.req_write = 4'b0100;
    c_if.req_addr[2*AW +: AW]  = 32'h1000_0040;
    c_if.req_wdata[2*LW +: LW] = pat;
    #1;
    check("wf_p0_gid", LW'(c_if.grant_id), LW'(0));
    check("wf_p0_read", LW'(c_if.mmu_read), LW'(1));
    check("wf_p0_write", LW'(c_if.mmu_write), LW'(0));
    check("wf_p0_addr", LW'(c_if.mmu_addr), LW'(32'h0000_0300));
    @(negedge sys_clk);
    c_if.mmu_done = 1'b1;
    #1;
    check("wf_p0_done", LW'(c_if.req_done), LW'(4'b0001));
    @(negedge sys_clk);
    c_if.mmu_done = 1'b0;
    c_if.req_read = 4'b0100;
    #1;
    check("wf_gap_gv", LW'(c_if.grant_valid), LW'(0));
    check("wf_gap_write", LW'(c_if.mmu_write), LW'(0));
    check("wf_gap_wdata", c_if.mmu_wdata, LW'(0));
    @(negedge sys_clk);
    #1;
    check("wf_p2_gid", LW'(c_if.grant_id), LW'(2));
    check("wf_p2_write", LW'(c_if.mmu_write), LW'(1));
    check("wf_p2_read", LW'(c_if.mmu_read), LW'(0));
    check("wf_p2_addr", LW'(c_if.mmu_addr), LW'(32'h1000_0040));
    check("wf_p2_wdata", c_if.mmu_wdata, pat);
    @(negedge sys_clk);
    c_if.mmu_done = 1'b1;
    #1;
    check("wf_p2_done", LW'(c_if.req_done), LW'(4'b0100));
    @(negedge sys_clk);
    c_if.mmu_done  = 1'b0;
    c_if.req_read  = '0;
    c_if.req_write = '0;
    #1;
    check("wf_end_done", LW'(c_if.req_done), LW'(0));

    repeat (3) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
